// File: rtl/sfp_ctrl_pkg.sv
// Shared definitions for the SFP cage manager.
//   port_state_t      : per-port link state (OFF=0, TX_ON=1, UP=2, FAULT=3)
//   FAULT_CNT_W       : width of the per-port fault entry counter
//   LOS_CNT_W         : width of the per-port LOS event counter
//   SYNC_RST_*        : reset value of each conditioned input (synchroniser
//                       flops and filtered value share it)
package sfp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TX_ON = 2'd1,
    ST_UP    = 2'd2,
    ST_FAULT = 2'd3
  } port_state_t;

  localparam int FAULT_CNT_W = 8;
  localparam int LOS_CNT_W   = 16;

  // Reset to "no module, no light, no fault" so a cold board keeps lasers off.
  localparam logic SYNC_RST_PRSNT_N  = 1'b1;
  localparam logic SYNC_RST_LOS      = 1'b1;
  localparam logic SYNC_RST_TX_FAULT = 1'b0;

  // The laser must be dark whenever the port is idle or recovering.
  function automatic logic laser_off(input port_state_t st);
    return (st == ST_OFF) || (st == ST_FAULT);
  endfunction

endpackage

// File: rtl/sfp_debounce.sv
// One-bit input conditioner: 2-flop synchroniser followed by a debounce
// counter. The filtered output only changes after the synchronised value has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk  : management clock
//   rst  : asynchronous active-high reset
//   raw  : asynchronous pin
//   filt : debounced, clk-domain value
module sfp_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   CNT_W           = 20,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             filt_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the pin and qualify any change for a full debounce window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= RST_VAL;
      sync2_r <= RST_VAL;
      filt_r  <= RST_VAL;
      cnt_r   <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r != filt_r) begin
        if (cnt_r == CNT_LAST) begin
          filt_r <= sync2_r;
          cnt_r  <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign filt = filt_r;

endmodule

// File: rtl/sfp_port_ctrl.sv
// Per-port SFP+ cage manager. Each port debounces its module pins and runs an
// OFF / TX_ON / UP / FAULT state machine that drives TXDISABLE and reports
// link and fault status.
// Optional feature: define SFP_LOS_STATS_EN to build the per-port 16-bit
// saturating LOS event counters; otherwise los_events is tied to zero.
// Ports:
//   clk, rst     : management clock, asynchronous active-high reset
//   enable       : software request to bring each port up
//   mod_prsnt_n  : raw pins, low = module present
//   los          : raw pins, high = loss of signal
//   tx_fault     : raw pins, high = transmitter fault
//   tx_disable   : laser off (high) per port
//   rate_sel     : 2 bits per port, held at 2'b00
//   link_up      : port is UP
//   fault        : port is in FAULT holdoff
//   fault_count  : 8 bits per port, saturating count of FAULT entries
//   los_events   : 16 bits per port, saturating UP->TX_ON count
module sfp_port_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int NUM_PORTS            = 4,
  parameter int DEBOUNCE_CYCLES      = 50000,
  parameter int FAULT_HOLDOFF_CYCLES = 500000,
  parameter int CNT_W                = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             enable,
  input  logic [NUM_PORTS-1:0]             mod_prsnt_n,
  input  logic [NUM_PORTS-1:0]             los,
  input  logic [NUM_PORTS-1:0]             tx_fault,
  output logic [NUM_PORTS-1:0]             tx_disable,
  output logic [2*NUM_PORTS-1:0]           rate_sel,
  output logic [NUM_PORTS-1:0]             link_up,
  output logic [NUM_PORTS-1:0]             fault,
  output logic [FAULT_CNT_W*NUM_PORTS-1:0] fault_count,
  output logic [LOS_CNT_W*NUM_PORTS-1:0]   los_events
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FAULT_HOLDOFF_CYCLES - 1);

  // Rate select is reserved for a later mode.
  assign rate_sel = {(2*NUM_PORTS){1'b0}};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic                   prsnt_n_f_s;
    logic                   los_f_s;
    logic                   fault_f_s;
    logic                   present_f_s;
    port_state_t            state_r;
    port_state_t            state_nxt_s;
    logic [CNT_W-1:0]       hold_r;
    logic [FAULT_CNT_W-1:0] fcnt_r;
    logic                   txd_r;
    logic                   up_r;
    logic                   flt_r;

    sfp_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RST_VAL         (SYNC_RST_PRSNT_N)
    ) u_db_prsnt (
      .clk  (clk),
      .rst  (rst),
      .raw  (mod_prsnt_n[i]),
      .filt (prsnt_n_f_s)
    );

    sfp_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RST_VAL         (SYNC_RST_LOS)
    ) u_db_los (
      .clk  (clk),
      .rst  (rst),
      .raw  (los[i]),
      .filt (los_f_s)
    );

    sfp_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .RST_VAL         (SYNC_RST_TX_FAULT)
    ) u_db_fault (
      .clk  (clk),
      .rst  (rst),
      .raw  (tx_fault[i]),
      .filt (fault_f_s)
    );

    assign present_f_s = ~prsnt_n_f_s;

    // Next-state decode; fault outranks enable/present, which outrank LOS.
    always_comb begin
      state_nxt_s = state_r;
      case (state_r)
        ST_OFF: begin
          if (enable[i] && present_f_s && !fault_f_s) state_nxt_s = ST_TX_ON;
          else                                        state_nxt_s = ST_OFF;
        end
        ST_TX_ON: begin
          if (fault_f_s)                        state_nxt_s = ST_FAULT;
          else if (!enable[i] || !present_f_s)  state_nxt_s = ST_OFF;
          else if (!los_f_s)                    state_nxt_s = ST_UP;
          else                                  state_nxt_s = ST_TX_ON;
        end
        ST_UP: begin
          if (fault_f_s)                        state_nxt_s = ST_FAULT;
          else if (!enable[i] || !present_f_s)  state_nxt_s = ST_OFF;
          else if (los_f_s)                     state_nxt_s = ST_TX_ON;
          else                                  state_nxt_s = ST_UP;
        end
        ST_FAULT: begin
          // Holdoff ends unconditionally; OFF then waits for the fault to clear.
          if (hold_r == HOLD_LAST) state_nxt_s = ST_OFF;
          else                     state_nxt_s = ST_FAULT;
        end
        default: state_nxt_s = ST_OFF;
      endcase
    end

    // State, holdoff timer, fault counter and outputs decoded from next state
    // so every output is a flop that lines up with the state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r <= ST_OFF;
        hold_r  <= '0;
        fcnt_r  <= '0;
        txd_r   <= 1'b1;
        up_r    <= 1'b0;
        flt_r   <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        txd_r   <= laser_off(state_nxt_s);
        up_r    <= (state_nxt_s == ST_UP);
        flt_r   <= (state_nxt_s == ST_FAULT);
        if ((state_nxt_s == ST_FAULT) && (state_r != ST_FAULT)) begin
          hold_r <= '0;
          if (fcnt_r != '1) fcnt_r <= fcnt_r + FAULT_CNT_W'(1);
        end else if (state_r == ST_FAULT) begin
          hold_r <= hold_r + CNT_W'(1);
        end
      end
    end

    assign tx_disable[i] = txd_r;
    assign link_up[i]    = up_r;
    assign fault[i]      = flt_r;
    assign fault_count[FAULT_CNT_W*i +: FAULT_CNT_W] = fcnt_r;

`ifdef SFP_LOS_STATS_EN
    logic [LOS_CNT_W-1:0] los_cnt_r;

    // Count UP->TX_ON drops, saturating; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        los_cnt_r <= '0;
      end else if ((state_r == ST_UP) && (state_nxt_s == ST_TX_ON) && (los_cnt_r != '1)) begin
        los_cnt_r <= los_cnt_r + LOS_CNT_W'(1);
      end
    end

    assign los_events[LOS_CNT_W*i +: LOS_CNT_W] = los_cnt_r;
`else
    assign los_events[LOS_CNT_W*i +: LOS_CNT_W] = {LOS_CNT_W{1'b0}};
`endif
  end

endmodule
